// File: rtl/systolic_mac_array.sv
// systolic_mac_array: 4x4 output-stationary systolic array computing C = A x B
// for unsigned 8-bit 4x4 matrices.
//
// Ports
//   clk       single clock, rising edge
//   st_rst    synchronous active-high reset
//   a_in      pre-skewed A wavefront word, row r in byte a_in[8*(3-r)+7 -: 8]
//   b_in      pre-skewed B wavefront word, column c in byte b_in[8*(3-c)+7 -: 8]
//   in_valid  a_in/b_in carry a wavefront word this cycle
//   in_ready  a word is accepted this cycle when in_valid is also high
//   c_out     accumulators, element r*4+c holds C[r][c]
//   done      c_out holds a complete product
//
// A pass is 7 accepted words followed by 3 drain cycles that push zeros in so
// the last operands reach PE(3,3). The first word of a pass loads products
// into the accumulators rather than adding, which clears the previous result.

module systolic_mac_array #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             st_rst,
  input  logic [31:0]      a_in,
  input  logic [31:0]      b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] c_out [0:15],
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  // Counts accepted words (1..7) and then drain cycles (7..10).
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       a_q   [0:15];
  logic [7:0]       b_q   [0:15];
  logic [ACC_W-1:0] acc_q [0:15];

  logic [7:0]       a_edge [0:3];
  logic [7:0]       b_edge [0:3];
  logic [7:0]       a_op   [0:15];
  logic [7:0]       b_op   [0:15];
  logic [15:0]      prod   [0:15];
  logic [ACC_W-1:0] acc_d  [0:15];

  logic accept, first, advance;

  assign in_ready = (state_q != DRAIN);
  assign accept   = in_valid && in_ready;
  assign first    = accept && ((state_q == IDLE) || (state_q == DONE));
  // Drain advances unconditionally; otherwise only an accepted word moves the grid.
  assign advance  = accept || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  // Edge operands: zeros during drain so nothing new enters the array.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a_edge[r] = (state_q == DRAIN) ? 8'd0 : a_in[8*(3-r) +: 8];
      b_edge[r] = (state_q == DRAIN) ? 8'd0 : b_in[8*(3-r) +: 8];
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_op[r*4+c] = a_edge[r];
      end else begin : g_a_left
        assign a_op[r*4+c] = a_q[r*4+c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_op[r*4+c] = b_edge[c];
      end else begin : g_b_up
        assign b_op[r*4+c] = b_q[(r-1)*4+c];
      end
      assign prod[r*4+c]  = {8'd0, a_op[r*4+c]} * {8'd0, b_op[r*4+c]};
      assign acc_d[r*4+c] = first ? ACC_W'(prod[r*4+c])
                                  : acc_q[r*4+c] + ACC_W'(prod[r*4+c]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = 4'd1;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd6) state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        a_q[i]   <= 8'd0;
        b_q[i]   <= 8'd0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (advance) begin
        for (int i = 0; i < 16; i++) begin
          a_q[i]   <= a_op[i];
          b_q[i]   <= b_op[i];
          acc_q[i] <= acc_d[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) c_out[i] = acc_q[i];
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: identity, saturation, stall,
// back-to-back, drain input masking and mid-run reset.
module tb_systolic_mac_array;

  logic        clk;
  logic        st_rst;
  logic [31:0] a_in, b_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] c_out [0:15];
  logic        done;

  int tests, fails, cyc, t0;
  logic [7:0]  ma [0:15];
  logic [7:0]  mb [0:15];
  logic [31:0] exp_c [0:15];

  systolic_mac_array #(.ACC_W(32)) dut (
    .clk      (clk),
    .st_rst   (st_rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .c_out    (c_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Skewed wavefront word k: row byte r = A[r][k-r], column byte c = B[k-c][c].
  function automatic logic [31:0] a_word(int k);
    logic [31:0] w = '0;
    for (int r = 0; r < 4; r++)
      if (k - r >= 0 && k - r <= 3) w[8*(3-r) +: 8] = ma[r*4 + (k-r)];
    return w;
  endfunction

  function automatic logic [31:0] b_word(int k);
    logic [31:0] w = '0;
    for (int c = 0; c < 4; c++)
      if (k - c >= 0 && k - c <= 3) w[8*(3-c) +: 8] = mb[(k-c)*4 + c];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends words 0..6; optional stall of stall_len cycles after word stall_after.
  task automatic send_pass(input int stall_after, input int stall_len);
    for (int k = 0; k < 7; k++) begin
      a_in = a_word(k);
      b_in = b_word(k);
      in_valid = 1'b1;
      step();
      if (k == 0) t0 = cyc;
      if (k == stall_after) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          a_in = 32'hDEAD_BEEF;
          b_in = 32'hCAFE_F00D;
          step();
          tests++;
          if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_in_ready: got %b want 1", in_ready);
          end
        end
      end
    end
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
  endtask

  // Waits for done (bounded), then checks edges elapsed since the first accept.
  task automatic wait_done(input string name, input int exp_lat);
    int guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    tests++;
    if (guard >= 40) begin
      fails++;
      $display("FAIL %s_timeout: done still %b after 40 cycles, want 1", name, done);
    end else if (cyc - t0 !== exp_lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, cyc - t0, exp_lat);
    end
  endtask

  task automatic set_identity_b();
    for (int i = 0; i < 16; i++) begin
      ma[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
      mb[i] = 8'(i + 1);
      exp_c[i] = 32'(i + 1);
    end
  endtask

  task automatic test_reset();
    st_rst = 1'b1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    step();
    step();
    st_rst = 1'b0;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== 32'd0) begin
        fails++;
        $display("FAIL reset_c_out[%0d]: got %0d want 0", i, c_out[i]);
      end
    end
  endtask

  task automatic test_identity();
    set_identity_b();
    send_pass(-1, 0);
    // Accept edge + 9 edges: done is high in the 10th cycle after the accept cycle.
    wait_done("identity", 9);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== exp_c[i]) begin
        fails++;
        $display("FAIL identity_c[%0d]: got %0d want %0d", i, c_out[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'd255;
      mb[i] = 8'd255;
    end
    send_pass(-1, 0);
    wait_done("saturation", 9);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== 32'h0003_F804) begin
        fails++;
        $display("FAIL saturation_c[%0d]: got %0d want 260100", i, c_out[i]);
      end
    end
  endtask

  task automatic test_stall();
    set_identity_b();
    send_pass(3, 2);
    wait_done("stall", 11);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== exp_c[i]) begin
        fails++;
        $display("FAIL stall_c[%0d]: got %0d want %0d", i, c_out[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_start_done: got %b want 1", done);
    end
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'd1;
      mb[i] = 8'd1;
    end
    a_in = a_word(0);
    b_in = b_word(0);
    in_valid = 1'b1;
    step();
    t0 = cyc;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done_drop: got %b want 0", done);
    end
    for (int k = 1; k < 7; k++) begin
      a_in = a_word(k);
      b_in = b_word(k);
      step();
    end
    in_valid = 1'b0;
    wait_done("b2b", 9);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== 32'd4) begin
        fails++;
        $display("FAIL b2b_c[%0d]: got %0d want 4", i, c_out[i]);
      end
    end
  endtask

  task automatic test_drain();
    set_identity_b();
    send_pass(-1, 0);
    // Now in DRAIN: drive junk with in_valid high for all three drain cycles.
    a_in = 32'hFFFF_FFFF;
    b_in = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL drain_in_ready[%0d]: got %b want 0", d, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL drain_done: got %b want 1", done);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== exp_c[i]) begin
        fails++;
        $display("FAIL drain_c[%0d]: got %0d want %0d", i, c_out[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_identity_b();
    for (int k = 0; k < 4; k++) begin
      a_in = a_word(k);
      b_in = b_word(k);
      in_valid = 1'b1;
      step();
    end
    a_in = a_word(4);
    b_in = b_word(4);
    st_rst = 1'b1;
    step();
    st_rst = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_done: got %b want 0", done);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== 32'd0) begin
        fails++;
        $display("FAIL midrst_c[%0d]: got %0d want 0", i, c_out[i]);
      end
    end
    // A = diag(1,2,3,4), B[i][j] = 4i+j+1 -> C[r][c] = (r+1)*(4r+c+1).
    for (int i = 0; i < 16; i++) ma[i] = (i / 4 == i % 4) ? 8'(i / 4 + 1) : 8'd0;
    exp_c = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd12, 32'd14, 32'd16,
              32'd27, 32'd30, 32'd33, 32'd36, 32'd52, 32'd56, 32'd60, 32'd64};
    send_pass(-1, 0);
    wait_done("midrst", 9);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (c_out[i] !== exp_c[i]) begin
        fails++;
        $display("FAIL midrst_c_after[%0d]: got %0d want %0d", i, c_out[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    t0 = 0;
    st_rst = 1'b1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    #1;
    test_reset();
    test_identity();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_mac_array.md
SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Parameter: ACC_W, default 32, accumulator and result width in bits; legal values 18 to 32.
REQ-003 SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port st_rst, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have the port a_in, input, 32 bits, pre-skewed A wavefront word; row r takes byte a_in[8*(3-r)+7 -: 8].
REQ-006 SHALL have the port b_in, input, 32 bits, pre-skewed B wavefront word; column c takes byte b_in[8*(3-c)+7 -: 8].
REQ-007 SHALL have the port in_valid, input, 1 bit, a_in and b_in carry a wavefront word this cycle.
REQ-008 SHALL have the port in_ready, output, 1 bit, the block accepts a word this cycle.
REQ-009 SHALL have the port c_out[0:15], output, ACC_W bits each; element r*4+c holds C[r][c].
REQ-010 SHALL have the port done, output, 1 bit, c_out holds a complete 4x4 product.

Function
REQ-011 SHALL compute C = A x B for 4x4 unsigned 8-bit matrices on a 4x4 grid of processing elements (PEs).
REQ-012 Each PE SHALL contain an a-register (passes right), a b-register (passes down) and an accumulator.
REQ-013 Wavefront word k (k = 0..6) SHALL carry A[r][k-r] in row byte r and B[k-c][c] in column byte c; bytes whose index falls outside 0..3 are 0.
REQ-014 A word SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-015 Shift rule: PE(r,0) takes a from a_in and PE(0,c) takes b from b_in; all other PEs take a and b from their left and upper neighbours' registers.
REQ-016 MAC rule: on each advance, every PE SHALL add (a operand x b operand) to its accumulator, using the same operands it registers.
REQ-017 Products SHALL be 16-bit unsigned and zero-extended to ACC_W; the maximum sum of 260100 fits, so there is no overflow or wrap.
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE or DONE with an accepted word: the word SHALL be wavefront 0, every accumulator SHALL load its product instead of adding, done SHALL clear, word count SHALL be 1, next state RUN.
REQ-020 RUN: each accepted word SHALL advance the grid and increment the count; after the 7th accepted word, next state DRAIN.
REQ-021 RUN with in_valid=0: the grid, accumulators and count SHALL all hold (stall); there is no stall limit.
REQ-022 DRAIN: the grid SHALL advance for exactly 3 cycles, injecting 0 on all edges and ignoring in_valid, then go to DONE.
REQ-023 in_ready SHALL be 1 in IDLE, RUN and DONE, and 0 in DRAIN.
REQ-024 done SHALL be 1 only in DONE; with no stalls it rises 10 cycles after the first accepted word's edge.
REQ-025 c_out SHALL continuously reflect the accumulators; its value is meaningful only while done=1, and it holds stable in DONE until the next accepted word.
REQ-026 Accepting a word in DONE (back-to-back pass) SHALL obey REQ-019 in the same cycle, so done drops on the next edge.

Reset
REQ-027 With st_rst=1 at an edge, the block SHALL go to IDLE and clear all PE registers, all accumulators and the word count; c_out=0 and done=0.
REQ-028 Reset SHALL take precedence over any accept, advance or stall in every state, including mid-RUN and mid-DRAIN.
REQ-029 After reset release, in_ready SHALL be 1 on the first cycle.

Verification
REQ-030 Identity: A=I and B[i][j]=4i+j+1, 7 consecutive valid words -> C=B (c_out[0]=1 ... c_out[15]=16), done high 10 cycles after the first accept.
REQ-031 Saturation: all A and B bytes 255 -> every c_out = 260100 (0x0003F804), no wrap.
REQ-032 Stall: same stimulus as REQ-030 with in_valid low for 2 cycles after word 3 -> identical C, done 12 cycles after the first accept, and in_ready stays 1 during the stall.
REQ-033 Back-to-back: in DONE, start a pass with A=B=all 1s -> every c_out = 4; no residue from the prior pass.
REQ-034 Reset mid-operation: st_rst pulsed during RUN word 4 -> next cycle state IDLE, c_out all 0, done 0; a following full pass gives the correct product.
REQ-035 DRAIN: in_valid held 1 throughout DRAIN -> in_ready=0 and the inputs are ignored (c_out unaffected by the a_in/b_in values driven).
